// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku display path: colour codes, scanner states,
// default grid geometry and the per-cell colour priority.
package sudoku_pkg;

  localparam int unsigned DEF_N       = 9;
  localparam int unsigned DEF_DIGIT_W = 4;

  typedef logic [1:0] color_t;

  localparam color_t COLOR_HIDDEN  = 2'b00;
  localparam color_t COLOR_VISIBLE = 2'b01;
  localparam color_t COLOR_ERROR   = 2'b10;
  localparam color_t COLOR_CURSOR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Cursor wins, then a blinking error, then plain revealed/hidden.
  function automatic color_t cell_color(input logic cursor_hit,
                                        input logic err_bit,
                                        input logic blink_on,
                                        input logic vis_bit);
    color_t c;
    if (cursor_hit)                c = COLOR_CURSOR;
    else if (err_bit && blink_on)  c = COLOR_ERROR;
    else if (vis_bit)              c = COLOR_VISIBLE;
    else                           c = COLOR_HIDDEN;
    return c;
  endfunction

endpackage

// File: rtl/sudoku_color_scanner_blink_timer.sv
// Free-running blink generator: phase toggles every BLINK_DIV clock cycles.
module blink_timer #(
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic phase
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sudoku_color_scanner.sv
// Frame scanner: snapshots the game state on start and streams one colour record
// per cell, row-major, over valid/ready; reports frame completion and victory.
module sudoku_color_scanner
  import sudoku_pkg::*;
#(
  parameter int unsigned N         = DEF_N,
  parameter int unsigned DIGIT_W   = DEF_DIGIT_W,
  parameter int unsigned IDX_W     = $clog2(N),
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N*N-1:0]         visibilities,
  input  logic [N*N-1:0]         errors,
  input  logic [N*N*DIGIT_W-1:0] board,
  input  logic [IDX_W-1:0]       cursor_i,
  input  logic [IDX_W-1:0]       cursor_j,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_i,
  output logic [IDX_W-1:0]       out_j,
  output logic [DIGIT_W-1:0]     out_digit,
  output logic [1:0]             out_color,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   victory
);

  localparam int unsigned C   = N * N;
  localparam int unsigned K_W = (C > 1) ? $clog2(C) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(C - 1);

  logic             blink_phase;

  logic [1:0]       state, state_nxt;
  logic [K_W-1:0]   cell_k, cell_k_nxt;
  logic             valid_nxt, busy_nxt, done_nxt, victory_nxt;
  logic [IDX_W-1:0] i_nxt, j_nxt;
  logic [DIGIT_W-1:0] digit_nxt;
  color_t           color_nxt;
  logic             capture;

  logic [IDX_W-1:0] adv_i, adv_j;
  logic [K_W-1:0]   adv_k;

  logic [C-1:0]       vis_snap;
  logic [C-1:0]       err_snap;
  logic [DIGIT_W-1:0] digit_snap [C];
  logic [IDX_W-1:0]   cur_i_snap, cur_j_snap;
  logic               phase_snap;

  blink_timer #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (blink_phase)
  );

  // Next cell in row-major order, j fastest.
  always_comb begin
    adv_k = cell_k + K_W'(1);
    if (out_j == IDX_LAST) begin
      adv_i = out_i + IDX_W'(1);
      adv_j = '0;
    end else begin
      adv_i = out_i;
      adv_j = out_j + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    valid_nxt   = out_valid;
    i_nxt       = out_i;
    j_nxt       = out_j;
    cell_k_nxt  = cell_k;
    digit_nxt   = out_digit;
    color_nxt   = out_color;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    victory_nxt = victory;

    case (state)
      ST_IDLE: begin
        if (start) begin
          // Cell (0,0) comes straight from the live inputs being captured this edge.
          capture    = 1'b1;
          state_nxt  = ST_SCAN;
          valid_nxt  = 1'b1;
          busy_nxt   = 1'b1;
          i_nxt      = '0;
          j_nxt      = '0;
          cell_k_nxt = '0;
          digit_nxt  = board[DIGIT_W-1:0];
          color_nxt  = cell_color((cursor_i == '0) && (cursor_j == '0),
                                  errors[0], blink_phase, visibilities[0]);
        end
      end

      ST_SCAN: begin
        if (out_valid && out_ready) begin
          if (cell_k == K_LAST) begin
            state_nxt   = ST_DONE;
            valid_nxt   = 1'b0;
            done_nxt    = 1'b1;
            victory_nxt = (&vis_snap) && !(|err_snap);
          end else begin
            i_nxt      = adv_i;
            j_nxt      = adv_j;
            cell_k_nxt = adv_k;
            digit_nxt  = digit_snap[adv_k];
            color_nxt  = cell_color((cur_i_snap == adv_i) && (cur_j_snap == adv_j),
                                    err_snap[adv_k], phase_snap, vis_snap[adv_k]);
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_i      <= '0;
      out_j      <= '0;
      cell_k     <= '0;
      out_digit  <= '0;
      out_color  <= COLOR_HIDDEN;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      victory    <= 1'b0;
    end else begin
      out_valid  <= valid_nxt;
      out_i      <= i_nxt;
      out_j      <= j_nxt;
      cell_k     <= cell_k_nxt;
      out_digit  <= digit_nxt;
      out_color  <= color_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
      victory    <= victory_nxt;
    end
  end

  // Frame snapshot; inputs are free to change once the scan has begun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_snap   <= '0;
      err_snap   <= '0;
      cur_i_snap <= '0;
      cur_j_snap <= '0;
      phase_snap <= 1'b0;
      for (int unsigned k = 0; k < C; k++) digit_snap[k] <= '0;
    end else if (capture) begin
      vis_snap   <= visibilities;
      err_snap   <= errors;
      cur_i_snap <= cursor_i;
      cur_j_snap <= cursor_j;
      phase_snap <= blink_phase;
      for (int unsigned k = 0; k < C; k++) digit_snap[k] <= board[k*DIGIT_W +: DIGIT_W];
    end
  end

endmodule

// File: tb/tb_sudoku_color_scanner.sv
// Directed scoreboard bench for sudoku_color_scanner (9x9 and 4x4 instances).
module tb_sudoku_color_scanner;

  localparam int N1 = 9, DW1 = 4, IW1 = 4, C1 = 81, BD1 = 5;
  localparam int N2 = 4, DW2 = 3, IW2 = 2, C2 = 16, BD2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                start, out_ready;
  logic [C1-1:0]       vis, err;
  logic [C1*DW1-1:0]   board;
  logic [IW1-1:0]      ci, cj;
  logic                out_valid, busy, frame_done, victory;
  logic [IW1-1:0]      out_i, out_j;
  logic [DW1-1:0]      out_digit;
  logic [1:0]          out_color;

  logic                start2, out_ready2;
  logic [C2-1:0]       vis2, err2;
  logic [C2*DW2-1:0]   board2;
  logic [IW2-1:0]      ci2, cj2;
  logic                out_valid2, busy2, frame_done2, victory2;
  logic [IW2-1:0]      out_i2, out_j2;
  logic [DW2-1:0]      out_digit2;
  logic [1:0]          out_color2;

  int total = 0;
  int bad   = 0;
  logic [13:0] q1 [$];
  logic [8:0]  q2 [$];

  int mcnt1, mcnt2;
  bit mph1, mph2;

  sudoku_color_scanner #(.N(N1), .DIGIT_W(DW1), .IDX_W(IW1), .BLINK_DIV(BD1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .visibilities(vis), .errors(err),
    .board(board), .cursor_i(ci), .cursor_j(cj), .out_valid(out_valid),
    .out_ready(out_ready), .out_i(out_i), .out_j(out_j), .out_digit(out_digit),
    .out_color(out_color), .busy(busy), .frame_done(frame_done), .victory(victory));

  sudoku_color_scanner #(.N(N2), .DIGIT_W(DW2), .IDX_W(IW2), .BLINK_DIV(BD2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .visibilities(vis2), .errors(err2),
    .board(board2), .cursor_i(ci2), .cursor_j(cj2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_i(out_i2), .out_j(out_j2), .out_digit(out_digit2),
    .out_color(out_color2), .busy(busy2), .frame_done(frame_done2), .victory(victory2));

  // Reference blink phases for both instances.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt1 <= 0; mph1 <= 1'b0; mcnt2 <= 0; mph2 <= 1'b0;
    end else begin
      if (mcnt1 == BD1 - 1) begin mcnt1 <= 0; mph1 <= ~mph1; end
      else mcnt1 <= mcnt1 + 1;
      if (mcnt2 == BD2 - 1) begin mcnt2 <= 0; mph2 <= ~mph2; end
      else mcnt2 <= mcnt2 + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_color(input int i, input int j, input int k, input int cur_i,
                                           input int cur_j, input bit e, input bit v, input bit ph);
    if (cur_i == i && cur_j == j) return 2'b11;
    if (e && ph) return 2'b10;
    if (v) return 2'b01;
    return 2'b00;
  endfunction

  task automatic push1(input bit ph);
    q1.delete();
    for (int i = 0; i < N1; i++)
      for (int j = 0; j < N1; j++) begin
        int k = i * N1 + j;
        logic [DW1-1:0] d = board[k*DW1 +: DW1];
        q1.push_back({IW1'(i), IW1'(j), d,
                      exp_color(i, j, k, int'(ci), int'(cj), err[k], vis[k], ph)});
      end
  endtask

  task automatic push2(input bit ph);
    q2.delete();
    for (int i = 0; i < N2; i++)
      for (int j = 0; j < N2; j++) begin
        int k = i * N2 + j;
        logic [DW2-1:0] d = board2[k*DW2 +: DW2];
        q2.push_back({IW2'(i), IW2'(j), d,
                      exp_color(i, j, k, int'(ci2), int'(cj2), err2[k], vis2[k], ph)});
      end
  endtask

  task automatic fill_board1();
    for (int k = 0; k < C1; k++) board[k*DW1 +: DW1] = DW1'($urandom_range(1, 9));
  endtask

  // One 9x9 frame; called and returns at a negedge.
  task automatic run1(input int rdy_pct, input bit disturb, input int abort_at);
    logic [13:0] exp, held;
    bit stalled = 1'b0, dist_done = 1'b0, exp_vic;
    int hs = 0, cyc = 0;
    push1(mph1);
    exp_vic = (&vis) && !(|err);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start", 64'(busy), 64'(1));
    while (hs < C1 && cyc < 4000) begin
      start = 1'b0;
      check("valid_in_scan", 64'(out_valid), 64'(1));
      check("no_early_done", 64'(frame_done), 64'(0));
      if (stalled) check("hold_stall", 64'({out_i, out_j, out_digit, out_color}), 64'(held));
      if (abort_at >= 0 && hs == abort_at) begin
        check("vic_pre_abort", 64'(victory), 64'(exp_vic));
        rst_n = 1'b0;
        #1;
        check("abort_reset_outs", 64'({out_valid, out_i, out_j, out_digit, out_color,
                                       busy, frame_done, victory}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", 64'({frame_done, busy, victory}), 64'(0));
        q1.delete();
        return;
      end
      stalled = 1'b0;
      if (out_valid) begin
        out_ready = (int'($urandom_range(99)) < rdy_pct);
        if (out_ready) begin
          exp = (q1.size() > 0) ? q1.pop_front() : 14'h3fff;
          check($sformatf("rec%0d", hs), 64'({out_i, out_j, out_digit, out_color}), 64'(exp));
          hs++;
        end else begin
          stalled = 1'b1;
          held = {out_i, out_j, out_digit, out_color};
        end
      end
      if (disturb && hs == 40 && !dist_done) begin
        start = 1'b1;
        vis = ~vis;
        err = C1'({$urandom(), $urandom(), $urandom()});
        fill_board1();
        ci = IW1'($urandom_range(0, 8));
        cj = IW1'($urandom_range(0, 8));
        dist_done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("handshakes", 64'(hs), 64'(C1));
    check("done_pulse", 64'(frame_done), 64'(1));
    check("valid_off_done", 64'(out_valid), 64'(0));
    check("busy_in_done", 64'(busy), 64'(1));
    check("victory", 64'(victory), 64'(exp_vic));
    if (rdy_pct == 100) check("done_latency", 64'(cyc), 64'(C1));
    @(negedge clk);
    check("done_single", 64'(frame_done), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    check("victory_hold", 64'(victory), 64'(exp_vic));
    @(negedge clk);
    check("no_requeue", 64'({busy, out_valid}), 64'(0));
  endtask

  // One 4x4 frame with ready held high.
  task automatic run2();
    logic [8:0] exp;
    bit exp_vic;
    int hs = 0, cyc = 0;
    push2(mph2);
    exp_vic = (&vis2) && !(|err2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    while (hs < C2 && cyc < 200) begin
      check("r2_valid", 64'(out_valid2), 64'(1));
      if (out_valid2) begin
        exp = (q2.size() > 0) ? q2.pop_front() : 9'h1ff;
        check($sformatf("r2_rec%0d", hs), 64'({out_i2, out_j2, out_digit2, out_color2}), 64'(exp));
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    check("r2_done", 64'({frame_done2, out_valid2}), 64'(2'b10));
    check("r2_latency", 64'(cyc), 64'(C2));
    check("r2_victory", 64'(victory2), 64'(exp_vic));
    @(negedge clk);
    check("r2_idle", 64'({busy2, frame_done2}), 64'(0));
  endtask

  task automatic wait_phase1(input bit want);
    int g = 0;
    while (mph1 != want && g < 40) begin
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    start = 1'b0; out_ready = 1'b0; vis = '1; err = '0; ci = '0; cj = '0;
    fill_board1();
    start2 = 1'b0; out_ready2 = 1'b1; vis2 = '1; err2 = '0; ci2 = 2'd1; cj2 = 2'd2;
    for (int k = 0; k < C2; k++) board2[k*DW2 +: DW2] = DW2'($urandom_range(1, 4));
    err2[5] = 1'b1; err2[10] = 1'b1; err2[15] = 1'b1; vis2[3] = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outs", 64'({out_valid, out_i, out_j, out_digit, out_color,
                            busy, frame_done, victory}), 64'(0));
    check("reset_outs2", 64'({out_valid2, out_i2, out_j2, out_digit2, out_color2,
                             busy2, frame_done2, victory2}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // All visible, cursor at origin.
    run1(100, 1'b0, -1);

    // Error at (4,5) with blink on, then off; cursor in the last cell.
    err[4*N1+5] = 1'b1; ci = 4'd8; cj = 4'd8;
    wait_phase1(1'b1);
    run1(100, 1'b0, -1);
    wait_phase1(1'b0);
    run1(100, 1'b0, -1);

    // Random backpressure.
    err = '0; ci = 4'd3; cj = 4'd7;
    run1(60, 1'b0, -1);

    // start pulsed and inputs scrambled mid-scan.
    run1(100, 1'b1, -1);
    vis = '1; err = '0; fill_board1();

    // One hidden cell; then off-grid cursor with a full board.
    vis[17] = 1'b0; ci = 4'd9; cj = 4'd3;
    run1(100, 1'b0, -1);
    vis = '1;
    run1(70, 1'b0, -1);

    // Reset at cell 40, then a clean frame afterwards.
    ci = 4'd2; cj = 4'd2;
    run1(100, 1'b0, 40);
    run1(100, 1'b0, -1);

    // 4x4 instance at staggered start times to sweep blink phase.
    for (int s = 0; s < 8; s++) begin
      repeat (s) @(negedge clk);
      run2();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
